fetch_queue_unit: RTL
=====================

Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined core; successor to the single-cycle PC/ifetch path.
- Owns the PC and issues sequential requests to a synchronous instruction memory (1-cycle read latency).
- Buffers {pc, instr} pairs in a DEPTH-entry FIFO with a valid/ready handshake to decode.
- Handles conditional/unconditional branch redirects (sign-extended, shifted-by-2 offsets) with flush of queue and in-flight fetch.

Parameters:
ADDR_W, 64, PC / instruction address width
INSTR_W, 32, instruction word width
DEPTH, 4, FIFO entries (power of two, >= 2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request issued this cycle
imem_addr  out  ADDR_W  fetch address, valid when imem_req=1
imem_rdata  in  INSTR_W  instruction for the request issued the previous cycle
redirect  in  1  branch taken; redirect fetch this cycle
redir_uncond  in  1  1: use imm26 (B), 0: use imm19 (CBZ/B.cond)
redir_pc  in  ADDR_W  PC of the branch instruction
redir_imm26  in  26  BrAddr26 field
redir_imm19  in  19  CondAddr19 field
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  INSTR_W  head instruction
out_pc  out  ADDR_W  head instruction address
occupancy  out  $clog2(DEPTH)+1  entries currently in FIFO

Behaviour:
- Reset (async, any cycle, including mid-fetch): fetch_pc=RESET_PC, FIFO empty, in-flight flag cleared, rd/wr pointers 0. Outputs while reset=1: imem_req=0, out_valid=0, occupancy=0, out_instr/out_pc=0.
- Issue rule: imem_req=1 when reset=0, redirect=0, and (occupancy + inflight) < DEPTH. Same-cycle dequeue is not credited. imem_addr=fetch_pc. On issue: fetch_pc <= fetch_pc+4 (mod 2^ADDR_W, wraps silently), inflight <= 1.
- Response: the cycle after an issue, {imem_rdata, issued address} is written at the FIFO tail unless killed. inflight clears that cycle unless a new issue occurs.
- Throughput: back-to-back issue every cycle while space permits. First request in the first cycle after reset deasserts. First out_valid=1 two cycles after reset deasserts.
- Dequeue: transfer when out_valid && out_ready; the head advances next edge. out_instr/out_pc come combinationally from the head entry.
- Simultaneous enqueue and dequeue: occupancy unchanged, both pointers advance. Full FIFO: the issue rule guarantees no overflow; enqueue when full is an assertion failure. Empty: out_valid=0, out_ready ignored.
- Redirect target = redir_pc + (sext(uncond ? imm26 : imm19) << 2), ADDR_W arithmetic, wraps.
- In a redirect cycle:
  - fetch_pc <= target.
  - FIFO flushed (pointers reset, occupancy->0 next cycle).
  - A response arriving this cycle is discarded.
  - A request issued the previous cycle is killed via epoch bit, so its data is never enqueued.
  - No issue this cycle; the target is issued the next cycle.
  - A dequeue handshake in the same cycle is valid (decode owns it); all other entries are dropped.
- Consecutive redirects: the last one wins; each flushes again.
- Pointers wrap modulo DEPTH. Occupancy is tracked by a counter, range 0..DEPTH.

Test Plan:
1. Reset release, out_ready=1, imem returns addr>>2 as data -> imem_addr 0,4,8,... every cycle. out_pc 0,4,8 with out_instr 0,1,2. out_valid first high 2 cycles after release.
2. out_ready=0 from start, DEPTH=4 -> exactly 4 requests (0..12), occupancy settles at 4, imem_req stays 0. Raise out_ready for one cycle -> one dequeue (pc 0), then one new request to 16.
3. Redirect redir_pc=0x40, uncond=1, imm26=0x3FFFFFE (-2) while FIFO holds 3 entries -> target 0x38. Next cycle occupancy=0, imem_addr=0x38. The killed in-flight response is never seen at out_pc.
4. Conditional redirect, redir_pc=0x100, imm19=5 -> target 0x114. Same-cycle out_ready handshake on head pc 0xF0 completes. No stale pc (>0xF0, <0x114) appears afterwards.
5. Async reset asserted mid-stream with occupancy=3 and inflight=1 -> imem_req and out_valid drop immediately (no clock edge). After release, fetch resumes at RESET_PC.
6. RESET_PC = 2^64-8 -> imem_addr sequence FFFF_FFFF_FFFF_FFF8, ..._FFFC, 0, 4.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, issues sequential requests to a
// 1-cycle-latency instruction memory, buffers {pc, instr} pairs in a small
// FIFO for decode, and redirects and flushes on taken branches.
//
// Handshake (decode side): an entry transfers on a rising edge where
// out_valid && out_ready. out_valid never depends on out_ready, and
// out_instr/out_pc are held stable while out_valid=1 and out_ready=0.
module fetch_queue_unit #(
  parameter int ADDR_W = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  input  logic                       redirect,
  input  logic                       redir_uncond,
  input  logic [ADDR_W-1:0]          redir_pc,
  input  logic [25:0]                redir_imm26,
  input  logic [18:0]                redir_imm19,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]       DEPTH_P = DEPTH[CW:0];
  localparam logic [CW-1:0]     DEPTH_C = DEPTH[CW-1:0];
  localparam logic [ADDR_W-1:0] STEP    = 4;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  inflight_addr;
  logic               inflight;
  logic               inflight_epoch;
  logic               epoch;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [ADDR_W-1:0]  mem_pc    [DEPTH];

  logic [CW:0]        pending;
  logic [ADDR_W-1:0]  offset;
  logic [ADDR_W-1:0]  target;
  logic               issue;
  logic               do_enq;
  logic               do_deq;

  // Issue, enqueue/dequeue qualification and branch target arithmetic.
  always_comb begin
    pending = {1'b0, count} + {{CW{1'b0}}, inflight};
    // Only entries already held or still in flight reserve space; a dequeue
    // this cycle is not credited, so the FIFO can never overflow.
    issue   = !reset && !redirect && (pending < DEPTH_P);
    // The epoch check drops any response that belongs to a fetch issued
    // before the most recent redirect.
    do_enq  = !reset && inflight && (inflight_epoch == epoch) && !redirect;
    do_deq  = out_valid && out_ready;
    if (redir_uncond) offset = {{(ADDR_W-26){redir_imm26[25]}}, redir_imm26};
    else              offset = {{(ADDR_W-19){redir_imm19[18]}}, redir_imm19};
    target  = redir_pc + (offset << 2);
  end

  // Outputs: head entry is presented combinationally; all forced low in reset.
  always_comb begin
    imem_req  = issue;
    imem_addr = fetch_pc;
    out_valid = !reset && (count != '0);
    out_instr = out_valid ? mem_instr[rd_ptr] : '0;
    out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;
    occupancy = reset ? '0 : count;
  end

  // PC, in-flight tracking, epoch, pointers and occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc       <= RESET_PC;
      inflight       <= 1'b0;
      inflight_addr  <= '0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_addr  <= fetch_pc;
        inflight_epoch <= epoch;
        fetch_pc       <= fetch_pc + STEP;
      end
      if (redirect) begin
        // Flush everything; a same-cycle dequeue already belongs to decode.
        fetch_pc <= target;
        epoch    <= ~epoch;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        assert (!(do_enq && count == DEPTH_C));
        if (do_enq) wr_ptr <= wr_ptr + 1'b1;
        if (do_deq) rd_ptr <= rd_ptr + 1'b1;
        case ({do_enq, do_deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]    <= inflight_addr;
    end
  end

endmodule
